// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 8 blocks x 16 bytes, 10-bit PC.
// Ports: CLK, RESET, PC, INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS,
//        MEM_READDATA, MEM_BUSYWAIT.
module instruction_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_UPDATE
  } state_t;

  state_t         state_q;
  logic [7:0]     valid_q;
  logic [2:0]     tag_q  [8];
  logic [127:0]   data_q [8];
  logic [5:0]     miss_addr_q;
  logic [127:0]   blk_q;
  logic           mem_read_q;

  logic [2:0]     pc_tag;
  logic [2:0]     pc_idx;
  logic [1:0]     pc_off;
  logic           hit;
  logic           unused_pc;

  assign pc_tag = PC[9:7];
  assign pc_idx = PC[6:4];
  assign pc_off = PC[3:2];
  assign unused_pc = ^{PC[31:10], PC[1:0]};

  assign hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  assign INSTRUCTION = data_q[pc_idx][{pc_off, 5'b0} +: 32];

  // Reset forces BUSYWAIT low so a CPU held in reset never sees a stall.
  always_comb begin
    BUSYWAIT = 1'b1;
    if (RESET)
      BUSYWAIT = 1'b0;
    else if (state_q == S_IDLE)
      BUSYWAIT = !hit;
  end

  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = miss_addr_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      blk_q       <= '0;
      mem_read_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!hit) begin
            miss_addr_q <= PC[9:4];
            mem_read_q  <= 1'b1;
            state_q     <= S_READ;
          end
        end
        S_READ: begin
          if (!MEM_BUSYWAIT) begin
            blk_q      <= MEM_READDATA;
            mem_read_q <= 1'b0;
            state_q    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          valid_q[miss_addr_q[2:0]] <= 1'b1;
          state_q                   <= S_IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; validity alone gates hits.
  // A reset during UPDATE returns state to IDLE first, so nothing is written.
  always_ff @(posedge CLK) begin
    if (state_q == S_UPDATE) begin
      tag_q[miss_addr_q[2:0]]  <= miss_addr_q[5:3];
      data_q[miss_addr_q[2:0]] <= blk_q;
    end
  end

endmodule
